alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/control unit that drives the 8-bit combinational ALU and consumes its result.
- Accepts 9-bit instruction words over a valid/ready handshake and holds an 8x8-bit register file.
- Per instruction: selects operands, drives the 3-bit ALU opcode, captures the ALU result, then writes back, performs a data-memory access, or reports a branch/jump to the fetch stage.

Parameters:
- DATA_W, 8, datapath width; fixed at 8, only present for readability.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles without mem_ack before mem_err is raised.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- instr_valid  in  1  instruction word present.
- instr  in  9  [8:6] op, [5:3] ra, [2:0] rb_or_imm.
- instr_ready  out  1  high only in IDLE.
- alu_instruction  out  3  registered ALU opcode; same encoding as the ISA op field.
- alu_input1  out  8  registered operand A.
- alu_input2  out  8  registered operand B.
- alu_result  in  8  combinational ALU result.
- mem_req  out  1  held high in MEM_WAIT.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  store data.
- mem_rdata  in  8  load data; valid when mem_ack is high.
- mem_ack  in  1  single-cycle completion.
- mem_err  out  1  one-cycle pulse on timeout.
- branch_taken  out  1  one-cycle pulse.
- jump_taken  out  1  one-cycle pulse.
- target  out  8  valid with branch_taken or jump_taken; equals r[ra].
- done  out  1  one-cycle pulse at instruction retire.
- dbg_addr  in  3  debug register-file read address.
- dbg_data  out  8  combinational r[dbg_addr].

Behaviour:
- Reset:
  - All 8 registers = 0x00; state = IDLE.
  - All outputs 0, except instr_ready = 1 (IDLE).
  - Reset in any state aborts the instruction; mem_req drops on the next edge; no write-back occurs.
- States: IDLE -> DECODE -> EXECUTE -> {WRITEBACK | MEM_WAIT} -> IDLE.
- IDLE:
  - instr_valid & instr_ready at edge N: latch instr, go to DECODE.
  - instr is ignored when instr_valid is low.
- DECODE (N+1):
  - Register alu_instruction = op.
  - alu_input1 = r[ra].
  - alu_input2 by op:
    - xor, beq: r[rb].
    - addi: sign-extended imm3 (range -4..+3).
    - andi: zero-extended imm3.
    - ls: {5'b0, imm3}.
    - ld, st, j: r[rb].
- EXECUTE (N+2): latch alu_result into res.
- WRITEBACK (N+3), by op:
  - xor, addi, andi, ls: r[ra] <= res; done pulses.
  - beq: branch_taken = (res == 0x00), target = r[ra], done pulses. The decision uses alu_result, never a separate zero flag. No register write.
  - j: jump_taken = 1, target = r[ra], done pulses.
  - Return to IDLE; instr_ready is high at N+4.
- MEM_WAIT (ld, st entered from EXECUTE):
  - mem_addr = r[rb].
  - st: mem_we = 1, mem_wdata = res (pass-through of r[ra]).
  - ld: mem_we = 0; on mem_ack, r[ra] <= mem_rdata.
  - On mem_ack: done pulses in the same cycle; go to IDLE.
  - Timeout: MEM_TIMEOUT cycles without mem_ack -> mem_err + done pulse, no write, go to IDLE.
- Write to r[ra] when ra == rb uses values captured in DECODE; no hazard (one instruction in flight).
- Latency:
  - Non-memory ops: 3 cycles from acceptance to done.
  - Memory ops: 3 + wait cycles.
  - Throughput: one instruction per 4 cycles minimum.
- Arithmetic: 8-bit wrap (0xFF + 1 = 0x00); no carry/overflow flags.
- Unsupported shift codes (000, 100) return the operand unchanged; the controller writes it back as-is.

Test Plan:
- Reset, then dbg_addr 0..7 -> dbg_data = 0x00 for all; instr_ready = 1; all pulses low.
- addi r1, +3 twice, then addi r1, -4 -> r1 = 0x03, 0x06, 0x02; done at exactly N+3 each time; instr_ready low N+1..N+3.
- r2 = 0xFF via addi chain, then addi r2, +1 -> r2 = 0x00 (wrap). ls r3 with code 111, r3 = 0x81 -> 0x02.
- beq r1, r1 -> branch_taken = 1, target = r1. beq r1, r2 with unequal values -> branch_taken = 0, done = 1, no register change.
- st r1 -> [r4], mem_ack after 2 cycles -> mem_we = 1, mem_addr = r4, mem_wdata = r1. ld r5 <- [r4] with mem_rdata = 0x5A -> r5 = 0x5A.
- ld with no mem_ack -> mem_err at the 15th MEM_WAIT cycle, r[ra] unchanged. Reset asserted in MEM_WAIT -> mem_req low next cycle, state IDLE, registers 0x00.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Multi-cycle issue/control unit for an 8-bit machine. It accepts one 9-bit
// instruction at a time, feeds registered operands and an opcode to an external
// combinational ALU, captures the ALU result, and then either writes it back to
// the 8x8 register file, runs a data-memory access, or reports a branch/jump.
//
// Instruction word: [8:6] op, [5:3] ra, [2:0] rb_or_imm
// Opcodes: 0 xor, 1 beq, 2 addi, 3 andi, 4 ls, 5 ld, 6 st, 7 j
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr[8:0]                 instruction word
//   alu_instruction[2:0]       registered opcode to the ALU
//   alu_input1/2[7:0]          registered ALU operands
//   alu_result[7:0]            combinational ALU result
//   mem_req, mem_we            memory request / write enable (MEM_WAIT only)
//   mem_addr, mem_wdata[7:0]   memory address / store data
//   mem_rdata[7:0], mem_ack    load data / single-cycle completion
//   mem_err                    pulse when the memory access times out
//   branch_taken, jump_taken   control-transfer pulses, with target[7:0]
//   done                       pulse when the instruction retires
//   dbg_addr[2:0], dbg_data    combinational register-file read port
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [8:0]        instr,
    output logic              instr_ready,
    output logic [2:0]        alu_instruction,
    output logic [DATA_W-1:0] alu_input1,
    output logic [DATA_W-1:0] alu_input2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err,
    output logic              branch_taken,
    output logic              jump_taken,
    output logic [DATA_W-1:0] target,
    output logic              done,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_LS   = 3'd4;
    localparam logic [2:0] OP_LD   = 3'd5;
    localparam logic [2:0] OP_ST   = 3'd6;
    localparam logic [2:0] OP_J    = 3'd7;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXECUTE,
        WRITEBACK,
        MEM_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [8:0]         r_instr;
    logic [DATA_W-1:0]  r_res;
    logic [DATA_W-1:0]  r_regs [8];
    logic [CNT_W-1:0]   r_waitCnt;

    logic [2:0]         w_op;
    logic [2:0]         w_ra;
    logic [2:0]         w_rb;
    logic [DATA_W-1:0]  w_operandB;
    logic               w_timeout;
    logic               w_regWe;
    logic [DATA_W-1:0]  w_regWdata;

    assign w_op     = r_instr[8:6];
    assign w_ra     = r_instr[5:3];
    assign w_rb     = r_instr[2:0];
    assign dbg_data = r_regs[dbg_addr];

    // Second ALU operand: register for reg-reg ops, immediate forms otherwise.
    always_comb begin
        w_operandB = r_regs[w_rb];
        case (w_op)
            OP_ADDI: w_operandB = {{(DATA_W-3){w_rb[2]}}, w_rb};
            OP_ANDI,
            OP_LS:   w_operandB = {{(DATA_W-3){1'b0}}, w_rb};
            default: w_operandB = r_regs[w_rb];
        endcase
    end

    // The last allowed MEM_WAIT cycle is the one whose counter reads
    // MEM_TIMEOUT-1; an ack in that same cycle still wins over the error.
    assign w_timeout = (r_state == MEM_WAIT) && !mem_ack &&
                       (r_waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and all handshake/pulse outputs are Moore-style decodes of the
    // current state, except the MEM_WAIT completion which reacts to mem_ack.
    always_comb begin
        w_nextState  = r_state;
        instr_ready  = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_err      = 1'b0;
        branch_taken = 1'b0;
        jump_taken   = 1'b0;
        target       = '0;
        done         = 1'b0;
        w_regWe      = 1'b0;
        w_regWdata   = '0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_nextState = DECODE;
                end
            end
            DECODE: begin
                w_nextState = EXECUTE;
            end
            EXECUTE: begin
                w_nextState = ((w_op == OP_LD) || (w_op == OP_ST)) ? MEM_WAIT : WRITEBACK;
            end
            WRITEBACK: begin
                done        = 1'b1;
                w_nextState = IDLE;
                case (w_op)
                    OP_BEQ: begin
                        branch_taken = (r_res == '0);
                        target       = r_regs[w_ra];
                    end
                    OP_J: begin
                        jump_taken = 1'b1;
                        target     = r_regs[w_ra];
                    end
                    OP_LD, OP_ST: ;
                    default: begin
                        w_regWe    = 1'b1;
                        w_regWdata = r_res;
                    end
                endcase
            end
            MEM_WAIT: begin
                mem_req   = 1'b1;
                mem_we    = (w_op == OP_ST);
                mem_addr  = r_regs[w_rb];
                mem_wdata = (w_op == OP_ST) ? r_res : '0;
                if (mem_ack) begin
                    done        = 1'b1;
                    w_nextState = IDLE;
                    if (w_op == OP_LD) begin
                        w_regWe    = 1'b1;
                        w_regWdata = mem_rdata;
                    end
                end else if (w_timeout) begin
                    mem_err     = 1'b1;
                    done        = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: instruction latch, ALU operand registers, result capture,
    // memory wait counter and the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr         <= '0;
            r_res           <= '0;
            r_waitCnt       <= '0;
            alu_instruction <= '0;
            alu_input1      <= '0;
            alu_input2      <= '0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                    end
                end
                DECODE: begin
                    alu_instruction <= w_op;
                    alu_input1      <= r_regs[w_ra];
                    alu_input2      <= w_operandB;
                end
                EXECUTE: begin
                    r_res     <= alu_result;
                    r_waitCnt <= '0;
                end
                MEM_WAIT: begin
                    r_waitCnt <= r_waitCnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (w_regWe) begin
                r_regs[w_ra] <= w_regWdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. The bench plays the role of the
// external ALU and data memory, and keeps an instruction-level model of the
// register file to predict results, pulses, latencies and memory traffic.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_ANDI = 3'd3;
    localparam logic [2:0] OP_LS   = 3'd4;
    localparam logic [2:0] OP_LD   = 3'd5;
    localparam logic [2:0] OP_ST   = 3'd6;
    localparam logic [2:0] OP_J    = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic [2:0] alu_instruction;
    logic [7:0] alu_input1, alu_input2, alu_result;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack, mem_err, branch_taken, jump_taken, done;
    logic [7:0] target;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_instruction(alu_instruction),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_result(alu_result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .branch_taken(branch_taken), .jump_taken(jump_taken), .target(target),
        .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Shift codes: 001/010/011 shift left by 1/2/3, 101/110 shift right by
    // 1/2, 111 arithmetic shift left by one; 000 and 100 leave the value alone.
    function automatic logic [7:0] shift_by_code(input logic [7:0] v, input logic [2:0] code);
        case (code)
            3'b001:  return v << 1;
            3'b010:  return v << 2;
            3'b011:  return v << 3;
            3'b101:  return v >> 1;
            3'b110:  return v >> 2;
            3'b111:  return v << 1;
            default: return v;
        endcase
    endfunction

    // External combinational ALU.
    function automatic logic [7:0] alu_env(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_XOR:  return a ^ b;
            OP_BEQ:  return a - b;
            OP_ADDI: return a + b;
            OP_ANDI: return a & b;
            OP_LS:   return shift_by_code(a, b[2:0]);
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_env(alu_instruction, alu_input1, alu_input2);

    // Instruction-level reference state and expectations.
    logic [7:0] mRegs [8];
    int         expLat;
    logic       expBranch, expJump, expErr, expMemReq, expMemWe;
    logic [7:0] expTarget, expMemAddr, expMemWdata;

    // Observations collected by the issue driver.
    int         obsLat, obsMemCycles;
    logic       obsBranch, obsJump, obsErr, obsStray, obsMemSeen, obsMemWe;
    logic       obsReadyStart, obsReadyLow, obsReadyAfter;
    logic [7:0] obsTarget, obsMemAddr, obsMemWdata;

    task automatic model_step(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                              input int ackAfter, input logic [7:0] rdata);
        logic [7:0] a, b;
        a = mRegs[ra];
        b = mRegs[rb];
        expLat = 3; expBranch = 0; expJump = 0; expErr = 0; expMemReq = 0; expMemWe = 0;
        expTarget = 8'h00; expMemAddr = 8'h00; expMemWdata = 8'h00;
        case (op)
            OP_XOR:  mRegs[ra] = a ^ b;
            OP_ADDI: mRegs[ra] = 8'(int'(a) + (rb[2] ? int'(rb) - 8 : int'(rb)));
            OP_ANDI: mRegs[ra] = a & {5'b00000, rb};
            OP_LS:   mRegs[ra] = shift_by_code(a, rb);
            OP_BEQ:  begin expBranch = (a == b); expTarget = a; end
            OP_J:    begin expJump = 1; expTarget = a; end
            default: begin
                expMemReq = 1;
                expMemAddr = b;
                expMemWe = (op == OP_ST);
                expMemWdata = (op == OP_ST) ? a : 8'h00;
                if (ackAfter < 0) begin
                    expErr = 1;
                    expLat = 2 + 15;
                end else begin
                    expLat = 3 + ackAfter;
                    if (op == OP_LD) mRegs[ra] = rdata;
                end
            end
        endcase
    endtask

    // Presents one instruction, plays the memory (ack in MEM_WAIT cycle
    // ackAfter+1, never if negative) and records what the DUT did.
    task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input int ackAfter, input logic [7:0] rdata);
        bit got;
        got = 0;
        obsLat = -1; obsMemCycles = 0; obsBranch = 0; obsJump = 0; obsErr = 0; obsStray = 0;
        obsMemSeen = 0; obsMemWe = 0; obsMemAddr = 8'h00; obsMemWdata = 8'h00; obsTarget = 8'h00;
        obsReadyLow = 1;
        @(negedge clk);
        obsReadyStart = instr_ready;
        instr_valid = 1'b1;
        instr = {op, ra, rb};
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 9'($urandom);
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                obsMemCycles++;
                if (!obsMemSeen) begin
                    obsMemSeen = 1; obsMemWe = mem_we; obsMemAddr = mem_addr; obsMemWdata = mem_wdata;
                end
                if (ackAfter >= 0 && obsMemCycles == ackAfter + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end
            #1;
            if (instr_ready) obsReadyLow = 0;
            if (done) begin
                got = 1;
                obsLat = cyc; obsBranch = branch_taken; obsJump = jump_taken;
                obsTarget = target; obsErr = mem_err;
            end else if (branch_taken || jump_taken || mem_err) begin
                obsStray = 1;
            end
            if (!got) @(negedge clk);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        obsReadyAfter = instr_ready;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = 9'h1FF; mem_ack = 1'b0; mem_rdata = 8'h00; dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if ({done, branch_taken, jump_taken, mem_req, mem_err, mem_we} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000000", {done, branch_taken, jump_taken, mem_req, mem_err, mem_we});
        end
        checks++; if ({alu_instruction, alu_input1, alu_input2, target} !== 27'h0) begin
            errors++; $display("FAIL reset_alu_outputs: got %h expected 0", {alu_instruction, alu_input1, alu_input2, target});
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            rd(3'(i), v);
            checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_addi();
        logic [2:0] imms [3];
        logic [7:0] want [3];
        logic [7:0] v;
        imms = '{3'b011, 3'b011, 3'b100};
        want = '{8'h03, 8'h06, 8'h02};
        for (int i = 0; i < 3; i++) begin
            model_step(OP_ADDI, 3'd1, imms[i], 0, 8'h00);
            issue(OP_ADDI, 3'd1, imms[i], 0, 8'h00);
            rd(3'd1, v);
            checks++; if (v !== want[i]) begin errors++; $display("FAIL addi_r1_%0d: got %h expected %h", i, v, want[i]); end
            checks++; if (obsLat !== 3) begin errors++; $display("FAIL addi_latency_%0d: got %0d expected 3", i, obsLat); end
            checks++; if ({obsReadyStart, obsReadyLow, obsReadyAfter} !== 3'b111) begin
                errors++; $display("FAIL addi_ready_%0d: got start/low/after %b expected 111", i, {obsReadyStart, obsReadyLow, obsReadyAfter});
            end
        end
    endtask

    task automatic test_wrap_ls();
        logic [2:0] ops [12];
        logic [2:0] ras [12];
        logic [2:0] imms [12];
        logic [7:0] want [12];
        logic [7:0] v;
        ops  = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_LS, OP_LS, OP_LS, OP_ADDI, OP_LS, OP_LS, OP_LS, OP_ADDI, OP_ANDI};
        ras  = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd6, 3'd6};
        imms = '{3'b111, 3'b001, 3'b001, 3'b011, 3'b011, 3'b001, 3'b001, 3'b111, 3'b000, 3'b100, 3'b111, 3'b110};
        want = '{8'hFF, 8'h00, 8'h01, 8'h08, 8'h40, 8'h80, 8'h81, 8'h02, 8'h02, 8'h02, 8'hFF, 8'h06};
        for (int i = 0; i < 12; i++) begin
            model_step(ops[i], ras[i], imms[i], 0, 8'h00);
            issue(ops[i], ras[i], imms[i], 0, 8'h00);
            rd(ras[i], v);
            checks++; if (v !== want[i]) begin errors++; $display("FAIL wrap_ls_step%0d: got %h expected %h", i, v, want[i]); end
        end
    endtask

    task automatic test_branch();
        logic [7:0] v;
        model_step(OP_BEQ, 3'd1, 3'd1, 0, 8'h00);
        issue(OP_BEQ, 3'd1, 3'd1, 0, 8'h00);
        checks++; if (obsBranch !== 1'b1) begin errors++; $display("FAIL beq_equal_taken: got %b expected 1", obsBranch); end
        checks++; if (obsTarget !== 8'h02) begin errors++; $display("FAIL beq_equal_target: got %h expected 02", obsTarget); end
        model_step(OP_BEQ, 3'd1, 3'd2, 0, 8'h00);
        issue(OP_BEQ, 3'd1, 3'd2, 0, 8'h00);
        checks++; if (obsBranch !== 1'b0 || obsLat !== 3) begin
            errors++; $display("FAIL beq_unequal: got taken %b latency %0d expected 0 and 3", obsBranch, obsLat);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++; if (v !== mRegs[i]) begin errors++; $display("FAIL beq_no_write_r%0d: got %h expected %h", i, v, mRegs[i]); end
        end
        model_step(OP_J, 3'd6, 3'd0, 0, 8'h00);
        issue(OP_J, 3'd6, 3'd0, 0, 8'h00);
        checks++; if (obsJump !== 1'b1 || obsTarget !== 8'h06 || obsBranch !== 1'b0) begin
            errors++; $display("FAIL jump: got jump %b target %h branch %b expected 1 06 0", obsJump, obsTarget, obsBranch);
        end
    endtask

    task automatic test_mem();
        logic [7:0] v;
        model_step(OP_ADDI, 3'd4, 3'b011, 0, 8'h00);
        issue(OP_ADDI, 3'd4, 3'b011, 0, 8'h00);
        model_step(OP_ST, 3'd1, 3'd4, 2, 8'h00);
        issue(OP_ST, 3'd1, 3'd4, 2, 8'h00);
        checks++; if ({obsMemSeen, obsMemWe} !== 2'b11 || obsMemAddr !== 8'h03 || obsMemWdata !== 8'h02) begin
            errors++; $display("FAIL store_bus: got req %b we %b addr %h wdata %h expected 1 1 03 02", obsMemSeen, obsMemWe, obsMemAddr, obsMemWdata);
        end
        checks++; if (obsLat !== 5 || obsErr !== 1'b0) begin errors++; $display("FAIL store_latency: got %0d err %b expected 5 0", obsLat, obsErr); end
        model_step(OP_LD, 3'd5, 3'd4, 0, 8'h5A);
        issue(OP_LD, 3'd5, 3'd4, 0, 8'h5A);
        rd(3'd5, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL load_r5: got %h expected 5A", v); end
        checks++; if (obsMemWe !== 1'b0 || obsMemAddr !== 8'h03 || obsLat !== 3) begin
            errors++; $display("FAIL load_bus: got we %b addr %h latency %0d expected 0 03 3", obsMemWe, obsMemAddr, obsLat);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] v;
        model_step(OP_LD, 3'd5, 3'd4, -1, 8'h00);
        issue(OP_LD, 3'd5, 3'd4, -1, 8'h00);
        checks++; if (obsErr !== 1'b1 || obsLat !== 17 || obsMemCycles !== 15) begin
            errors++; $display("FAIL timeout: got err %b latency %0d wait %0d expected 1 17 15", obsErr, obsLat, obsMemCycles);
        end
        checks++; if (obsStray !== 1'b0) begin errors++; $display("FAIL timeout_early_pulse: got %b expected 0", obsStray); end
        rd(3'd5, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL timeout_r5: got %h expected 5A", v); end
    endtask

    task automatic test_reset_memwait();
        logic [7:0] v;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {OP_LD, 3'd2, 3'd4};
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL memwait_entry: got mem_req %b expected 1", mem_req); end
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 8'hC3;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
        #1;
        checks++; if ({mem_req, instr_ready, done} !== 3'b010) begin
            errors++; $display("FAIL memwait_reset: got req/ready/done %b expected 010", {mem_req, instr_ready, done});
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++; if (v !== 8'h00) begin errors++; $display("FAIL memwait_reset_r%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op, ra, rb;
        logic [7:0] rdata, v;
        int ackAfter;
        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            ra = 3'($urandom);
            rb = 3'($urandom);
            rdata = 8'($urandom);
            ackAfter = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
            model_step(op, ra, rb, ackAfter, rdata);
            issue(op, ra, rb, ackAfter, rdata);
            checks++; if (obsLat !== expLat) begin errors++; $display("FAIL rand%0d_latency op%0d: got %0d expected %0d", n, op, obsLat, expLat); end
            checks++; if ({obsBranch, obsJump, obsErr, obsStray} !== {expBranch, expJump, expErr, 1'b0}) begin
                errors++; $display("FAIL rand%0d_pulses op%0d: got %b expected %b", n, op, {obsBranch, obsJump, obsErr, obsStray}, {expBranch, expJump, expErr, 1'b0});
            end
            if (op == OP_BEQ || op == OP_J) begin
                checks++; if (obsTarget !== expTarget) begin errors++; $display("FAIL rand%0d_target: got %h expected %h", n, obsTarget, expTarget); end
            end
            checks++; if (obsMemSeen !== expMemReq) begin errors++; $display("FAIL rand%0d_memreq op%0d: got %b expected %b", n, op, obsMemSeen, expMemReq); end
            if (expMemReq) begin
                checks++; if ({obsMemWe, obsMemAddr, obsMemWdata} !== {expMemWe, expMemAddr, expMemWdata}) begin
                    errors++; $display("FAIL rand%0d_membus: got we %b addr %h wdata %h expected %b %h %h", n, obsMemWe, obsMemAddr, obsMemWdata, expMemWe, expMemAddr, expMemWdata);
                end
            end
            for (int i = 0; i < 8; i++) begin
                rd(3'(i), v);
                checks++; if (v !== mRegs[i]) begin errors++; $display("FAIL rand%0d_r%0d op%0d: got %h expected %h", n, i, op, v, mRegs[i]); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_wrap_ls();
        test_branch();
        test_mem();
        test_timeout();
        test_reset_memwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
